// File: rtl/uart_mmio_tx.sv
// rtl/uart_mmio_tx.sv - memory-mapped console: THR/RBR/LSR registers, TX FIFO and drain FSM
module uart_mmio_tx #(
  parameter logic [63:0] BASE_ADDR  = 64'h1000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          TX_GAP     = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        mmio_wen_i,
  input  logic        mmio_ren_i,
  input  logic [63:0] mmio_addr_i,
  input  logic [63:0] mmio_wdata_i,
  output logic [63:0] mmio_rdata_o,
  output logic        uart_out_valid_o,
  output logic [7:0]  uart_out_ch_o,
  output logic        uart_in_valid_o,
  input  logic [7:0]  uart_in_ch_i,
  output logic        tx_busy_o,
  output logic [31:0] tx_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;

  typedef enum logic {IDLE, GAP} state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  state_e        state_q;
  logic [GW-1:0] gap_q;
  logic          out_valid_q;
  logic [7:0]    out_ch_q;
  logic [31:0]   tx_count_q;

  logic       hit, full, empty, push_req, push, pop, lsr_rd;
  logic [2:0] off;
  logic [7:0] wr_byte, lsr, rd_byte;

  assign hit      = (mmio_addr_i[63:3] == BASE_ADDR[63:3]);
  assign off      = mmio_addr_i[2:0];
  assign wr_byte  = mmio_wdata_i[{off, 3'b000} +: 8];
  assign full     = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign pop      = (state_q == IDLE) && !empty;
  assign push_req = mmio_wen_i && hit && (off == 3'd0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = push_req && (!full || pop);
  assign lsr_rd   = mmio_ren_i && hit && (off == 3'd5);

  assign tx_busy_o       = !empty || (state_q != IDLE);
  assign lsr             = {1'b0, !tx_busy_o, !full, 3'b000, overflow_q, 1'b1};
  assign uart_in_valid_o = mmio_ren_i && hit && (off == 3'd0);

  always_comb begin
    rd_byte = 8'h00;
    if (mmio_ren_i && hit) begin
      case (off)
        3'd0:    rd_byte = uart_in_ch_i;
        3'd5:    rd_byte = lsr;
        default: rd_byte = 8'h00;
      endcase
    end
  end

  assign mmio_rdata_o = 64'(rd_byte) << {off, 3'b000};

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    // A fresh drop wins over the read-to-clear in the same cycle.
    overflow_d = overflow_q;
    if (lsr_rd)              overflow_d = 1'b0;
    if (push_req && !push)   overflow_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_byte;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      gap_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= 8'h00;
      tx_count_q  <= 32'd0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            out_valid_q <= 1'b1;
            out_ch_q    <= mem_q[rd_ptr_q];
            tx_count_q  <= tx_count_q + 32'd1;
            if (TX_GAP > 0) begin
              state_q <= GAP;
              gap_q   <= GW'(TX_GAP - 1);
            end
          end
        end
        GAP: begin
          if (gap_q == '0) state_q <= IDLE;
          else             gap_q   <= gap_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Masking with reset keeps a strobe queued before reset from appearing in the reset cycle.
  assign uart_out_valid_o = out_valid_q && !rst_i;
  assign uart_out_ch_o    = out_ch_q;
  assign tx_count_o       = tx_count_q;

endmodule

// File: tb/tb_uart_mmio_tx.sv
// tb/tb_uart_mmio_tx.sv - directed self-checking bench for uart_mmio_tx (TX_GAP 0 and 3)
module tb_uart_mmio_tx;

  localparam logic [63:0] BASE = 64'h1000_0000;

  logic        clk = 1'b0;
  logic        rst, wen, ren;
  logic [63:0] addr, wdata;
  logic [7:0]  in_ch;

  logic [63:0] a_rdata, b_rdata;
  logic        a_valid, b_valid, a_iv, b_iv, a_busy, b_busy;
  logic [7:0]  a_ch, b_ch;
  logic [31:0] a_cnt, b_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] a_ch_q[$], b_ch_q[$];
  int         a_cyc_q[$], b_cyc_q[$];

  uart_mmio_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .TX_GAP(0)) u_dut_g0 (
    .clk_i(clk), .rst_i(rst), .mmio_wen_i(wen), .mmio_ren_i(ren),
    .mmio_addr_i(addr), .mmio_wdata_i(wdata), .mmio_rdata_o(a_rdata),
    .uart_out_valid_o(a_valid), .uart_out_ch_o(a_ch), .uart_in_valid_o(a_iv),
    .uart_in_ch_i(in_ch), .tx_busy_o(a_busy), .tx_count_o(a_cnt)
  );

  uart_mmio_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .TX_GAP(3)) u_dut_g3 (
    .clk_i(clk), .rst_i(rst), .mmio_wen_i(wen), .mmio_ren_i(ren),
    .mmio_addr_i(addr), .mmio_wdata_i(wdata), .mmio_rdata_o(b_rdata),
    .uart_out_valid_o(b_valid), .uart_out_ch_o(b_ch), .uart_in_valid_o(b_iv),
    .uart_in_ch_i(in_ch), .tx_busy_o(b_busy), .tx_count_o(b_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (a_valid) begin a_ch_q.push_back(a_ch); a_cyc_q.push_back(cyc); end
    if (b_valid) begin b_ch_q.push_back(b_ch); b_cyc_q.push_back(cyc); end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    a_ch_q.delete(); a_cyc_q.delete();
    b_ch_q.delete(); b_cyc_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; wen = 1'b0; ren = 1'b0; addr = '0; wdata = '0;
    repeat (3) step();
    rst = 1'b0;
    clear_q();
  endtask

  task automatic wr(input logic [63:0] a, input logic [7:0] b);
    addr  = a;
    wdata = 64'(b) << {a[2:0], 3'b000};
    wen   = 1'b1;
    step();
    wen   = 1'b0;
    addr  = '0;
  endtask

  task automatic rd(input logic [63:0] a, input bit use_b, output logic [63:0] d, output logic iv);
    addr = a;
    ren  = 1'b1;
    #1;
    d  = use_b ? b_rdata : a_rdata;
    iv = use_b ? b_iv : a_iv;
    step();
    ren  = 1'b0;
    addr = '0;
  endtask

  initial begin
    logic [63:0] d;
    logic        iv;
    logic [7:0]  hello [5];
    int          t0;
    hello = '{8'h48, 8'h45, 8'h4c, 8'h4c, 8'h4f};
    in_ch = 8'h00;

    // Reset state
    do_reset();
    check_eq("rst_valid", a_valid, 0);
    check_eq("rst_ch", a_ch, 0);
    check_eq("rst_count", a_cnt, 0);
    check_eq("rst_busy_g0", a_busy, 0);
    check_eq("rst_busy_g3", b_busy, 0);
    check_eq("rst_rdata", a_rdata, 0);
    check_eq("rst_in_valid", a_iv, 0);
    rd(BASE + 5, 1'b0, d, iv);
    check_eq("rst_lsr", d, 64'h0000_6100_0000_0000);

    // Single byte: strobe exactly two cycles after the write
    t0 = cyc;
    wr(BASE, 8'h41);
    repeat (5) step();
    check_eq("single_n", a_ch_q.size(), 1);
    if (a_ch_q.size() >= 1) begin
      check_eq("single_ch", a_ch_q[0], 8'h41);
      check_eq("single_cyc", a_cyc_q[0], t0 + 2);
    end
    check_eq("single_count", a_cnt, 1);
    rd(BASE + 5, 1'b0, d, iv);
    check_eq("single_lsr", d[47:40], 8'h61);

    // HELLO burst back-to-back
    do_reset();
    t0 = cyc;
    for (int i = 0; i < 5; i++) wr(BASE, hello[i]);
    repeat (6) step();
    check_eq("hello_n", a_ch_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < a_ch_q.size()) begin
        check_eq($sformatf("hello_ch%0d", i), a_ch_q[i], hello[i]);
        check_eq($sformatf("hello_cyc%0d", i), a_cyc_q[i], t0 + 2 + i);
      end
    end
    check_eq("hello_count", a_cnt, 5);
    rd(BASE + 5, 1'b0, d, iv);
    check_eq("hello_lsr", d[47:40], 8'h61);

    // Overflow at TX_GAP=3: pops land at burst cycles 1, 5 and 9, so 11 of 12 fit
    do_reset();
    t0 = cyc;
    for (int i = 0; i < 12; i++) wr(BASE, 8'h30 + 8'(i));
    rd(BASE + 5, 1'b1, d, iv);
    check_eq("ovf_set", d[41], 1);
    check_eq("ovf_full", d[45], 0);
    rd(BASE + 5, 1'b1, d, iv);
    check_eq("ovf_clr", d[41], 0);
    repeat (40) step();
    check_eq("ovf_n", b_ch_q.size(), 11);
    for (int i = 0; i < 11; i++) begin
      if (i < b_ch_q.size()) begin
        check_eq($sformatf("ovf_ch%0d", i), b_ch_q[i], 8'h30 + 8'(i));
        check_eq($sformatf("ovf_cyc%0d", i), b_cyc_q[i], t0 + 2 + 4 * i);
      end
    end
    check_eq("ovf_count", b_cnt, 11);
    check_eq("ovf_busy", b_busy, 0);
    rd(BASE + 5, 1'b1, d, iv);
    check_eq("ovf_lsr_end", d[47:40], 8'h61);

    // RX path and address decode
    do_reset();
    in_ch = 8'h7a;
    rd(BASE, 1'b0, d, iv);
    check_eq("rx_data", d, 64'h7a);
    check_eq("rx_valid", iv, 1);
    rd(BASE + 3, 1'b0, d, iv);
    check_eq("rx_off3_data", d, 0);
    check_eq("rx_off3_valid", iv, 0);
    rd(BASE + 8, 1'b0, d, iv);
    check_eq("miss_rdata", d, 0);
    check_eq("miss_valid", iv, 0);
    wr(BASE + 8, 8'h55);
    wr(BASE + 1, 8'h66);
    repeat (4) step();
    check_eq("miss_wr_n", a_ch_q.size(), 0);
    check_eq("miss_wr_busy", a_busy, 0);

    // Reset one cycle after the first strobe of a 4-byte queue
    do_reset();
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) rst = 1'b1;
      wr(BASE, 8'h61 + 8'(i));
    end
    rst = 1'b0;
    repeat (10) step();
    check_eq("mid_n", a_ch_q.size(), 1);
    if (a_ch_q.size() >= 1) check_eq("mid_ch", a_ch_q[0], 8'h61);
    check_eq("mid_count", a_cnt, 0);
    check_eq("mid_busy", a_busy, 0);
    rd(BASE + 5, 1'b0, d, iv);
    check_eq("mid_lsr", d[47:40], 8'h61);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
